// File: rtl/project_mux_pkg.sv
// -----------------------------------------------------------------------------
// project_mux_pkg
// Shared definitions for the project IO-pad mux controller:
//   - Wishbone register offsets (CTRL, STATUS, CLRERR)
//   - STATUS register bit positions
//   - FSM state encoding
//   - helper that assembles the STATUS read word
// -----------------------------------------------------------------------------
package project_mux_pkg;

  // Register offsets, decoded from adr[7:0]
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CLRERR = 8'h08;

  // STATUS layout: [7:0] cur_id, then the flag bits below
  localparam int STAT_ANY_BIT  = 8;
  localparam int STAT_BUSY_BIT = 9;
  localparam int STAT_ERR_BIT  = 10;

  // OFF    : no project owns the pads
  // SWITCH : break-before-make guard, every active line held low
  // ON     : project cur_id owns the pads
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SWITCH = 2'd1,
    ST_ON     = 2'd2
  } mux_state_t;

  function automatic logic [31:0] pack_status(input logic [7:0] cur_id,
                                              input logic       any_active,
                                              input logic       busy,
                                              input logic       err);
    logic [31:0] s;
    s                = '0;
    s[7:0]           = cur_id;
    s[STAT_ANY_BIT]  = any_active;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_ERR_BIT]  = err;
    return s;
  endfunction

endpackage

// File: rtl/project_mux_ctrl_wb_reg_if.sv
// -----------------------------------------------------------------------------
// wb_reg_if
// Wishbone slave front end for the project mux controller: address decode,
// single-cycle registered ack, registered read mux and write strobes.
//
// Handshake: a transfer is requested while cyc & stb are high and the address
// hits the 256-byte window at BASE_ADDR. ack is registered (ack <= hit & ~ack),
// so it rises exactly one cycle after the request and lasts one cycle. The
// master holds its request until it sees ack. Write strobes fire in the ack
// cycle, so each transfer produces exactly one side effect, at the clock edge
// that ends the ack cycle. A miss is never acked and leaves rdata at 0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cyc, stb, we  Wishbone cycle / strobe / write enable
//   adr           Wishbone address
//   ctrl_rdata    CTRL read value from the core
//   status_rdata  STATUS read value from the core
//   ack           Wishbone acknowledge (registered)
//   rdata         Wishbone read data (registered, 0 except on read acks)
//   ctrl_wr       CTRL write strobe (one cycle)
//   clrerr_wr     CLRERR write strobe (one cycle)
// -----------------------------------------------------------------------------
module wb_reg_if
  import project_mux_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] ctrl_rdata,
  input  logic [31:0] status_rdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        ctrl_wr,
  output logic        clrerr_wr
);

  logic        hit;
  logic [7:0]  offset;
  logic [31:0] rd_mux;

  assign hit    = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]);
  assign offset = adr[7:0];

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_CTRL:   rd_mux = ctrl_rdata;
      OFF_STATUS: rd_mux = status_rdata;
      default:    rd_mux = '0;
    endcase
  end

  // rdata is captured on the request cycle so it is stable for the whole
  // ack cycle, and falls back to 0 everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= hit & ~ack;
      rdata <= (hit & ~ack & ~we) ? rd_mux : '0;
    end
  end

  assign ctrl_wr   = ack & hit & we & (offset == OFF_CTRL);
  assign clrerr_wr = ack & hit & we & (offset == OFF_CLRERR);

endmodule

// File: rtl/project_mux_ctrl.sv
// -----------------------------------------------------------------------------
// project_mux_ctrl
// Selects which wrapped project owns the shared IO pads. Software writes a
// pending (enable, id) pair into CTRL; the controller drives a one-hot-or-zero
// active line per project and enforces break-before-make: every active line is
// held low for GUARD_CYCLES cycles before a new project is enabled.
//
// Parameters:
//   NUM_PROJECTS  number of projects / width of active_o (2..256)
//   GUARD_CYCLES  cycles all active lines stay low during a switch (>= 1)
//   BASE_ADDR     Wishbone base address, decoded on bits [31:8]
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs_*_i / wbs_*_o    Wishbone slave interface
//   active_o             one-hot-or-zero project enables
//   busy_o               high while a switch (guard interval) is in progress
// -----------------------------------------------------------------------------
module project_mux_ctrl
  import project_mux_pkg::*;
#(
  parameter int          NUM_PROJECTS = 16,
  parameter int          GUARD_CYCLES = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    busy_o
);

  localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0]           GUARD_LOAD = CW'(GUARD_CYCLES - 1);
  localparam logic [NUM_PROJECTS-1:0] ONE_LSB    = NUM_PROJECTS'(1);
  localparam logic [8:0]              ID_LIMIT   = 9'(NUM_PROJECTS);

  // FSM state and registers, kept as plain named signals for checkers
  mux_state_t    state;
  logic [7:0]    cur_id;
  logic [7:0]    pend_id;
  logic          pend_en;
  logic          err;
  logic [CW-1:0] guard_cnt;

  logic          ctrl_wr;
  logic          clrerr_wr;
  logic [31:0]   ctrl_rdata;
  logic [31:0]   status_rdata;

  // Pending values a CTRL write would produce, honouring byte selects
  logic          new_en;
  logic [7:0]    new_id;
  logic          new_id_ok;
  logic          new_target_on;
  logic          pend_target_on;
  logic [NUM_PROJECTS-1:0] pend_onehot;

  logic          unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_dat_i[7:1]};

  wb_reg_if #(
    .BASE_ADDR (BASE_ADDR)
  ) u_wb_reg_if (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .cyc          (wbs_cyc_i),
    .stb          (wbs_stb_i),
    .we           (wbs_we_i),
    .adr          (wbs_adr_i),
    .ctrl_rdata   (ctrl_rdata),
    .status_rdata (status_rdata),
    .ack          (wbs_ack_o),
    .rdata        (wbs_dat_o),
    .ctrl_wr      (ctrl_wr),
    .clrerr_wr    (clrerr_wr)
  );

  always_comb begin
    new_en         = wbs_sel_i[0] ? wbs_dat_i[0]    : pend_en;
    new_id         = wbs_sel_i[1] ? wbs_dat_i[15:8] : pend_id;
    new_id_ok      = ({1'b0, new_id} < ID_LIMIT);
    new_target_on  = new_en & new_id_ok;
    pend_target_on = pend_en & ({1'b0, pend_id} < ID_LIMIT);
    // Only used when pend_id is in range, so the shift never drops the bit.
    pend_onehot    = ONE_LSB << pend_id;
  end

  assign ctrl_rdata   = {16'b0, pend_id, 7'b0, pend_en};
  assign status_rdata = pack_status(cur_id, |active_o, busy_o, err);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_OFF;
      cur_id    <= '0;
      pend_id   <= '0;
      pend_en   <= 1'b0;
      err       <= 1'b0;
      guard_cnt <= '0;
      active_o  <= '0;
      busy_o    <= 1'b0;
    end else begin
      if (clrerr_wr) begin
        err <= 1'b0;
      end

      if (ctrl_wr) begin
        pend_en <= new_en;
        pend_id <= new_id;
        if (new_en && !new_id_ok) begin
          err <= 1'b1;
        end
        case (state)
          ST_SWITCH: begin
            // Any write mid-guard restarts the full guard interval.
            guard_cnt <= GUARD_LOAD;
          end
          ST_ON: begin
            if (!(new_target_on && (new_id == cur_id))) begin
              state     <= ST_SWITCH;
              guard_cnt <= GUARD_LOAD;
              active_o  <= '0;
              busy_o    <= 1'b1;
            end
          end
          default: begin
            if (new_target_on) begin
              state     <= ST_SWITCH;
              guard_cnt <= GUARD_LOAD;
              active_o  <= '0;
              busy_o    <= 1'b1;
            end
          end
        endcase
      end else if (state == ST_SWITCH) begin
        if (guard_cnt == '0) begin
          // Guard done: target is re-evaluated from the latest pending values.
          busy_o <= 1'b0;
          if (pend_target_on) begin
            state    <= ST_ON;
            cur_id   <= pend_id;
            active_o <= pend_onehot;
          end else begin
            state    <= ST_OFF;
          end
        end else begin
          guard_cnt <= guard_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_project_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_project_mux_ctrl
// Directed bench for project_mux_ctrl. Every Wishbone transfer pushes its
// expected read data (0 for writes) into exp_q; a monitor compares wbs_dat_o
// on every ack. The main thread checks active_o / busy_o timing around
// switches, and an always-on checker enforces one-hot-or-zero active_o.
// -----------------------------------------------------------------------------
module tb_project_mux_ctrl;

  localparam int          NP   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;
  localparam logic [31:0] A_CLRERR = BASE + 32'h08;
  localparam logic [31:0] A_OTHER  = BASE + 32'h0C;
  localparam logic [31:0] A_MISS   = BASE + 32'h104;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we  = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = '0;
  logic [31:0]   dat = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic [NP-1:0] active;
  logic          busy;

  project_mux_ctrl #(
    .NUM_PROJECTS (NP),
    .GUARD_CYCLES (8),
    .BASE_ADDR    (BASE)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .active_o  (active),
    .busy_o    (busy)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  string       name_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack is matched against the oldest expected response.
  always @(negedge clk) begin
    if (ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ack with data %h, required no ack", rdat);
      end else begin
        logic [31:0] e, m;
        string       n;
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        n = name_q.pop_front();
        if ((rdat & m) !== (e & m)) begin
          bad++;
          $display("FAIL %s: got %h expected %h (mask %h)", n, rdat & m, e & m, m);
        end
      end
    end
  end

  // Never two projects on the pads at once.
  always @(negedge clk) begin
    total++;
    if ($countones(active) > 1) begin
      bad++;
      $display("FAIL onehot: got active=%h, required at most one bit", active);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the ack cycle has ended.
  task automatic drive_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string name);
    int lat;
    bit got;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
      else     lat++;
    end
    total++;
    if (!got || lat != 1) begin
      bad++;
      $display("FAIL ack_latency %s: got lat=%0d seen=%0d, required lat=1 seen=1", name, lat, got);
    end
    if (!got) begin
      void'(exp_q.pop_back());
      void'(mask_q.pop_back());
      void'(name_q.pop_back());
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string name);
    exp_q.push_back(32'h0);
    mask_q.push_back(32'hFFFF_FFFF);
    name_q.push_back(name);
    drive_xfer(1'b1, a, d, s, name);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input logic [31:0] m,
                         input string name);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(name);
    drive_xfer(1'b0, a, 32'h0, 4'hF, name);
  endtask

  // Active lines low and busy high for the 8 guard cycles, then final value.
  task automatic check_switch(input logic [NP-1:0] final_active, input string name);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk({name, "_guard_busy"},   32'(busy),   32'h1);
      chk({name, "_guard_active"}, 32'(active), 32'h0);
    end
    @(negedge clk);
    chk({name, "_final_active"}, 32'(active), 32'(final_active));
    chk({name, "_final_busy"},   32'(busy),   32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_steady(input logic [NP-1:0] exp_active, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({name, "_busy"},   32'(busy),   32'h0);
      chk({name, "_active"}, 32'(active), 32'(exp_active));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_busy_cycles(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({name, "_busy"},   32'(busy),   32'h1);
      chk({name, "_active"}, 32'(active), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_ack",    32'(ack),    32'h0);
    chk("rst_dat",    rdat,        32'h0);
    @(posedge clk);
    #1;

    wb_read(A_STATUS, 32'h0000_0000, 32'hFFFF_FFFF, "rd_status_reset");
    wb_read(A_CTRL,   32'h0000_0000, 32'hFFFF_FFFF, "rd_ctrl_reset");

    // Address outside the window: no ack, read data stays 0.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_MISS; sel = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("miss_ack", 32'(ack), 32'h0);
      chk("miss_dat", rdat,     32'h0);
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;

    // OFF -> ON(3)
    wb_write(A_CTRL, 32'h0000_0301, 4'hF, "wr_ctrl_on3");
    check_switch(16'h0008, "sw_on3");
    wb_read(A_STATUS, 32'h0000_0103, 32'hFFFF_FFFF, "rd_status_on3");

    // Same target: no guard interval
    wb_write(A_CTRL, 32'h0000_0301, 4'hF, "wr_ctrl_same3");
    check_steady(16'h0008, 10, "same3");

    // ON(3) -> ON(5)
    wb_write(A_CTRL, 32'h0000_0501, 4'hF, "wr_ctrl_on5");
    check_switch(16'h0020, "sw_on5");
    wb_read(A_STATUS, 32'h0000_0105, 32'hFFFF_FFFF, "rd_status_on5");

    // No byte selects: pending values untouched, nothing switches
    wb_write(A_CTRL, 32'h0000_0701, 4'h0, "wr_ctrl_nosel");
    check_steady(16'h0020, 4, "nosel");
    wb_read(A_CTRL, 32'h0000_0501, 32'hFFFF_FFFF, "rd_ctrl_nosel");

    // Read-only / unmapped offsets
    wb_write(A_STATUS, 32'hFFFF_FFFF, 4'hF, "wr_status_ignored");
    wb_write(A_OTHER,  32'h0000_1234, 4'hF, "wr_other_ignored");
    wb_read(A_OTHER,  32'h0000_0000, 32'hFFFF_FFFF, "rd_other");
    wb_read(A_CLRERR, 32'h0000_0000, 32'hFFFF_FFFF, "rd_clrerr");
    wb_read(A_STATUS, 32'h0000_0105, 32'hFFFF_FFFF, "rd_status_after_ignored");

    // Out-of-range id: guard then OFF, sticky error
    wb_write(A_CTRL, 32'h0000_1401, 4'hF, "wr_ctrl_bad_id");
    check_switch(16'h0000, "sw_bad_id");
    wb_read(A_STATUS, 32'h0000_0400, 32'h0000_0700, "rd_status_err");
    wb_read(A_CTRL,   32'h0000_1401, 32'hFFFF_FFFF, "rd_ctrl_bad_id");
    wb_write(A_CLRERR, 32'h0000_0000, 4'hF, "wr_clrerr");
    wb_read(A_STATUS, 32'h0000_0000, 32'h0000_0700, "rd_status_cleared");

    // Guard restart: id 2, then id 7 four cycles later
    wb_write(A_CTRL, 32'h0000_0201, 4'hF, "wr_ctrl_id2");
    check_busy_cycles(2, "restart_gap");
    wb_write(A_CTRL, 32'h0000_0701, 4'hF, "wr_ctrl_id7");
    check_switch(16'h0080, "sw_restart");

    // Reset in the middle of a guard interval
    wb_write(A_CTRL, 32'h0000_0301, 4'hF, "wr_ctrl_pre_reset");
    check_busy_cycles(3, "pre_reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_active", 32'(active), 32'h0);
    chk("midrst_busy",   32'(busy),   32'h0);
    @(posedge clk);
    #1;
    check_steady(16'h0000, 10, "post_reset");
    wb_read(A_STATUS, 32'h0000_0000, 32'hFFFF_FFFF, "rd_status_post_reset");
    wb_read(A_CTRL,   32'h0000_0000, 32'hFFFF_FFFF, "rd_ctrl_post_reset");

    // Drain the scoreboard
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d outstanding responses, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/project_mux_ctrl.md
Name: project_mux_ctrl

Overview:
- Wishbone-configured controller that selects which project in the group submission owns the shared IO pads.
- Drives one one-hot `active` line per wrapped project. A deasserted line makes that project tristate its io_out/io_oeb.
- Enforces break-before-make switchover: all active lines are low for a guard interval before the new project is enabled.
- Sits in user_project_wrapper, in place of tying each project's active input directly to a logic-analyser bit.

Parameters:
- NUM_PROJECTS, 16, number of wrapped projects / width of active_o; must be 2..256.
- GUARD_CYCLES, 8, number of cycles all active lines stay low during a switch; must be >= 1.
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode uses bits [31:8].

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  Wishbone byte selects.
- wbs_adr_i  in  32  Wishbone address.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  Wishbone read data.
- active_o  out  NUM_PROJECTS  one-hot-or-zero project enables.
- busy_o  out  1  high while a switch is in progress.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: active_o=0, busy_o=0, wbs_ack_o=0, wbs_dat_o=0, FSM=OFF, cur_id=0, pend_id=0, pend_en=0, err=0.
- Address decode: hit = cyc & stb & (adr[31:8]==BASE_ADDR[31:8]).
  - On a miss, the block gives no ack and wbs_dat_o=0.
- Ack timing: wbs_ack_o is registered, ack <= hit & ~ack. This gives exactly one ack cycle, one cycle after the request. The block inserts no further wait states.
- Registers (offset adr[7:0]):
  - 0x00 CTRL (RW):
    - bit0 = enable, updated only when sel[0].
    - bits[15:8] = project id, updated only when sel[1].
    - Reads return {16'b0, pend_id, 7'b0, pend_en}.
  - 0x04 STATUS (RO):
    - bits[7:0] = cur_id.
    - bit8 = any active.
    - bit9 = busy.
    - bit10 = err (sticky).
    - Writes are acked and ignored.
  - 0x08 CLRERR (WO): a write of any value clears err. Reads return 0.
  - Other offsets: reads return 0; writes are acked and ignored.
- Register side effects occur in the cycle the ack is asserted (once per transfer).
- FSM state OFF: active_o=0.
- FSM state SWITCH: active_o=0, busy_o=1, guard counter counting down from GUARD_CYCLES-1.
- FSM state ON: active_o = 1<<cur_id.
- A CTRL write produces new pending values (pend_en, pend_id). From these, "target" is computed:
  - target = ON(pend_id) if pend_en and pend_id<NUM_PROJECTS.
  - target = OFF otherwise.
  - If pend_en=1 and pend_id>=NUM_PROJECTS, err is set; the target is OFF.
- Transition rules on a CTRL write:
  - If the target equals the present steady state (OFF->OFF, or ON with the same id), the FSM does not change and no guard interval runs.
  - Otherwise the FSM goes to SWITCH, and active_o drops to 0 on the next clock edge.
- A CTRL write while in SWITCH updates the pending values and reloads the guard counter (restart).
- SWITCH exit: after GUARD_CYCLES cycles with active_o=0, the FSM re-evaluates target.
  - If target is ON: go to ON, cur_id<=pend_id.
  - Otherwise: go to OFF.
  - busy_o falls in the same cycle.
- Invariant: at most one bit of active_o is set in any cycle. There is never a cycle where the old and new project are both active.
- Reset mid-switch or mid-transfer: the block returns to reset values on the next edge. Any in-flight Wishbone transfer is not acked.

Decomposition:
- Shared package project_mux_pkg:
  - register offsets CTRL/STATUS/CLRERR;
  - STATUS bit positions;
  - FSM state encoding (OFF, SWITCH, ON).
- Sub-module wb_reg_if handles decode, ack generation, read mux and write strobes.
- FSM, guard counter and one-hot decode stay in project_mux_ctrl.

Test Plan:
- Reset, then read STATUS -> 0x0000_0000; active_o=0; ack arrives exactly 1 cycle after stb.
- Write CTRL=0x0301 -> busy_o high for 8 cycles with active_o=0, then active_o=0x0008 and STATUS=0x0000_0103.
- While ON(3), write CTRL=0x0501 -> active_o goes 0 the next cycle, stays 0 for 8 cycles, then 0x0020. Never two bits high at once.
- Write CTRL=0x0301 while ON(3) -> no busy pulse; active_o stays 0x0008.
- Write CTRL=0x1401 (id 20 >= 16) -> after guard, active_o=0 and STATUS bit10=1. Write CLRERR -> bit10=0.
- Write id 2 (CTRL=0x0201), then id 7 (CTRL=0x0701) 4 cycles later -> the guard restarts; the final active_o=0x0080 appears 8 cycles after the second write. Asserting reset mid-guard -> active_o=0, busy_o=0.
